// File: rtl/axi_stream_dw_downsizer.sv
// axi_stream_dw_downsizer
// Splits each wide AXI Stream beat into DataWidthIn/DataWidthOut narrow
// beats. The least-significant slice is sent first. One wide beat is
// buffered. The next wide beat is accepted in the same cycle that the
// last slice leaves, so back-to-back beats are sent without bubbles.
//
// Optional build macro AXI_STREAM_DW_DOWNSIZER_SKIP_NULL_EN:
//   When defined, trailing slices whose keep bits are all zero are not
//   emitted, and tlast moves to the last slice that is emitted.
//   When undefined, all slices are always emitted.
module axi_stream_dw_downsizer #(
  parameter int unsigned DataWidthIn  = 64,
  parameter int unsigned DataWidthOut = 8,
  parameter int unsigned IdWidth      = 0,
  parameter int unsigned DestWidth    = 0,
  parameter int unsigned UserWidth    = 0,
  parameter type axi_stream_in_req_t = struct packed {
    logic tvalid;
    struct packed {
      logic [DataWidthIn-1:0]                      data;
      logic [DataWidthIn/8-1:0]                    strb;
      logic [DataWidthIn/8-1:0]                    keep;
      logic                                        last;
      logic [(IdWidth   > 0 ? IdWidth   : 1)-1:0]  id;
      logic [(DestWidth > 0 ? DestWidth : 1)-1:0]  dest;
      logic [(UserWidth > 0 ? UserWidth : 1)-1:0]  user;
    } t;
  },
  parameter type axi_stream_in_rsp_t = struct packed { logic tready; },
  parameter type axi_stream_out_req_t = struct packed {
    logic tvalid;
    struct packed {
      logic [DataWidthOut-1:0]                     data;
      logic [DataWidthOut/8-1:0]                   strb;
      logic [DataWidthOut/8-1:0]                   keep;
      logic                                        last;
      logic [(IdWidth   > 0 ? IdWidth   : 1)-1:0]  id;
      logic [(DestWidth > 0 ? DestWidth : 1)-1:0]  dest;
      logic [(UserWidth > 0 ? UserWidth : 1)-1:0]  user;
    } t;
  },
  parameter type axi_stream_out_rsp_t = struct packed { logic tready; }
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_stream_in_req_t  in_req_i,
  output axi_stream_in_rsp_t  in_rsp_o,
  output axi_stream_out_req_t out_req_o,
  input  axi_stream_out_rsp_t out_rsp_i
);

  localparam int unsigned N     = DataWidthIn / DataWidthOut;
  localparam int unsigned SW    = DataWidthOut / 8;
  localparam int unsigned CW    = $clog2(N);
  localparam int unsigned IdW   = (IdWidth   > 0) ? IdWidth   : 1;
  localparam int unsigned DestW = (DestWidth > 0) ? DestWidth : 1;
  localparam int unsigned UserW = (UserWidth > 0) ? UserWidth : 1;
  localparam logic [CW-1:0] LastIdx = CW'(N - 1);

  if ((DataWidthIn <= DataWidthOut) || (DataWidthIn % DataWidthOut != 0)) begin : g_param_fail
    $fatal(1, "axi_stream_dw_downsizer: DataWidthIn must be a larger integer multiple of DataWidthOut");
  end

  // Buffered wide beat. Slices are viewed as packed rows so that the
  // current slice can be selected directly by the counter.
  logic [N-1:0][DataWidthOut-1:0] data_q;
  logic [N-1:0][SW-1:0]           strb_q;
  logic [N-1:0][SW-1:0]           keep_q;
  logic                           last_q;
  logic [IdW-1:0]                 id_q;
  logic [DestW-1:0]               dest_q;
  logic [UserW-1:0]               user_q;
  logic                           valid_q;
  logic [CW-1:0]                  counter_q;
  logic [CW-1:0]                  last_idx_q;
  logic [CW-1:0]                  last_idx_d;

  logic at_last;
  logic in_ready;
  logic in_hs;
  logic out_hs;

  assign at_last  = (counter_q == last_idx_q);
  assign in_ready = !valid_q || (out_rsp_i.tready && at_last);
  assign in_hs    = in_req_i.tvalid && in_ready;
  assign out_hs   = valid_q && out_rsp_i.tready;

`ifdef AXI_STREAM_DW_DOWNSIZER_SKIP_NULL_EN
  logic [N-1:0] slice_nz;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_slice_nz
    assign slice_nz[gi] = |in_req_i.t.keep[gi*SW +: SW];
  end

  // The highest slice with any keep bit set is the last one emitted. An all-null
  // beat still emits slice 0, so that its last, id, dest and user are not lost.
  always_comb begin
    last_idx_d = '0;
    for (int i = 0; i < N; i++) begin
      if (slice_nz[i]) last_idx_d = CW'(i);
    end
  end
`else
  assign last_idx_d = LastIdx;
`endif

  // Wide-side ready. It depends combinationally on the narrow-side ready, so
  // that a new beat can be loaded in the same cycle that the last slice is sent.
  always_comb begin
    in_rsp_o        = '0;
    in_rsp_o.tready = in_ready;
  end

  // Narrow-side outputs come only from the buffer registers.
  always_comb begin
    out_req_o        = '0;
    out_req_o.tvalid = valid_q;
    out_req_o.t.data = data_q[counter_q];
    out_req_o.t.strb = strb_q[counter_q];
    out_req_o.t.keep = keep_q[counter_q];
    out_req_o.t.last = last_q && at_last;
    out_req_o.t.id   = id_q;
    out_req_o.t.dest = dest_q;
    out_req_o.t.user = user_q;
  end

  // Loading the buffer takes priority. When a beat is accepted, the previous
  // beat's last slice is sent in the same cycle, so no slice is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q     <= '0;
      strb_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      id_q       <= '0;
      dest_q     <= '0;
      user_q     <= '0;
      valid_q    <= 1'b0;
      counter_q  <= '0;
      last_idx_q <= '0;
    end else if (in_hs) begin
      data_q     <= in_req_i.t.data;
      strb_q     <= in_req_i.t.strb;
      keep_q     <= in_req_i.t.keep;
      last_q     <= in_req_i.t.last;
      id_q       <= in_req_i.t.id;
      dest_q     <= in_req_i.t.dest;
      user_q     <= in_req_i.t.user;
      valid_q    <= 1'b1;
      counter_q  <= '0;
      last_idx_q <= last_idx_d;
    end else if (out_hs) begin
      if (!at_last) begin
        counter_q <= counter_q + CW'(1);
      end else begin
        counter_q <= '0;
        valid_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_dw_downsizer.sv
// Bench for axi_stream_dw_downsizer: 64-bit input, 16-bit output.
// A slice-queue model is loaded on every accepted wide beat and compared
// against the narrow stream on every cycle. Directed literal checks pin the model.
module tb_axi_stream_dw_downsizer;

  localparam int N  = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [1:0]  user;
  } in_t_t;
  typedef struct packed { logic tvalid; in_t_t t; } in_req_t;
  typedef struct packed { logic tready; } in_rsp_t;
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  strb;
    logic [1:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [1:0]  user;
  } out_t_t;
  typedef struct packed { logic tvalid; out_t_t t; } out_req_t;
  typedef struct packed { logic tready; } out_rsp_t;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  in_req_t  in_req;
  in_rsp_t  in_rsp;
  out_req_t out_req;
  out_rsp_t out_rsp;

  axi_stream_dw_downsizer #(
    .DataWidthIn          (64),
    .DataWidthOut         (16),
    .IdWidth              (4),
    .DestWidth            (4),
    .UserWidth            (2),
    .axi_stream_in_req_t  (in_req_t),
    .axi_stream_in_rsp_t  (in_rsp_t),
    .axi_stream_out_req_t (out_req_t),
    .axi_stream_out_rsp_t (out_rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_req_i  (in_req),
    .in_rsp_o  (in_rsp),
    .out_req_o (out_req),
    .out_rsp_i (out_rsp)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          low_cnt = 0;
  bit          rdy_pattern = 1'b0;
  out_t_t      exp_q[$];
  logic [15:0] got_data[$];
  logic [1:0]  got_keep[$];
  logic        got_last[$];
  logic [3:0]  got_id[$];
  logic [3:0]  got_dest[$];
  int          got_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an accepted wide beat becomes an ordered list of narrow slices.
  // With null skipping, the list ends at the highest slice that has any
  // keep bit set. At least one slice is always emitted.
  task automatic push_beat(input in_t_t b);
    int     cnt;
    out_t_t s;
    cnt = N;
`ifdef AXI_STREAM_DW_DOWNSIZER_SKIP_NULL_EN
    cnt = 1;
    for (int i = 0; i < N; i++) if (b.keep[i*SW +: SW] != 0) cnt = i + 1;
`endif
    for (int i = 0; i < cnt; i++) begin
      s.data = b.data[i*16 +: 16];
      s.strb = b.strb[i*SW +: SW];
      s.keep = b.keep[i*SW +: SW];
      s.last = b.last && (i == cnt - 1);
      s.id   = b.id;
      s.dest = b.dest;
      s.user = b.user;
      exp_q.push_back(s);
    end
  endtask

  // Compare process runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("out_tvalid", 64'(out_req.tvalid), 64'(exp_q.size() != 0));
      check("in_tready", 64'(in_rsp.tready),
            64'((exp_q.size() == 0) || (exp_q.size() == 1 && out_rsp.tready)));
      if (out_req.tvalid && exp_q.size() != 0)
        check("out_slice", 64'(out_req.t), 64'(exp_q[0]));
      if (out_req.tvalid && !in_rsp.tready) low_cnt++;
      if (out_req.tvalid && out_rsp.tready) begin
        $display("out beat cyc=%0d data=%h strb=%h keep=%h last=%b id=%h dest=%h user=%h",
                 cyc, out_req.t.data, out_req.t.strb, out_req.t.keep, out_req.t.last,
                 out_req.t.id, out_req.t.dest, out_req.t.user);
        got_data.push_back(out_req.t.data);
        got_keep.push_back(out_req.t.keep);
        got_last.push_back(out_req.t.last);
        got_id.push_back(out_req.t.id);
        got_dest.push_back(out_req.t.dest);
        got_cyc.push_back(cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_req.tvalid && in_rsp.tready) push_beat(in_req.t);
    end
  end

  // Narrow-side ready is either held high or follows the pattern 1,0,0,1,0,0,...
  initial begin
    int k;
    k = 0;
    out_rsp.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_pattern) begin
        out_rsp.tready = (k % 3 == 0);
        k++;
      end else begin
        out_rsp.tready = 1'b1;
        k = 0;
      end
    end
  end

  task automatic clear_log();
    got_data.delete(); got_keep.delete(); got_last.delete();
    got_id.delete(); got_dest.delete(); got_cyc.delete();
    low_cnt = 0;
  endtask

  // Drives one wide beat and holds it until it is accepted.
  // tvalid stays high afterwards, so that the caller can send back-to-back beats.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] strb, input logic [7:0] keep,
                           input logic last, input logic [3:0] id, input logic [3:0] dest,
                           input logic [1:0] user);
    bit done;
    done = 1'b0;
    in_req.tvalid = 1'b1;
    in_req.t.data = d;
    in_req.t.strb = strb;
    in_req.t.keep = keep;
    in_req.t.last = last;
    in_req.t.id   = id;
    in_req.t.dest = dest;
    in_req.t.user = user;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_rsp.tready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("in_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && !out_req.tvalid) break;
      @(posedge clk);
      #1;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] t1_exp [4];
    bit          done;
    t1_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    in_req = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_tvalid", 64'(out_req.tvalid), 64'(0));
    check("rst_out_fields", 64'(out_req.t), 64'(0));
    check("rst_in_tready", 64'(in_rsp.tready), 64'(1));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // A single beat with ready held high.
    clear_log();
    send_beat(64'h4444_3333_2222_1111, 8'hFF, 8'hFF, 1'b1, 4'h1, 4'h1, 2'h0);
    in_req.tvalid = 1'b0;
    drain();
    check("t1_count", 64'(got_data.size()), 64'(4));
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      check("t1_data", 64'(got_data[i]), 64'(t1_exp[i]));
      check("t1_keep", 64'(got_keep[i]), 64'(2'h3));
      check("t1_last", 64'(got_last[i]), 64'(i == 3));
    end
    check("t1_in_tready_low_cycles", 64'(low_cnt), 64'(3));

    // Three back-to-back beats.
    clear_log();
    send_beat(64'hA003_A002_A001_A000, 8'hFF, 8'hFF, 1'b0, 4'h2, 4'h3, 2'h1);
    send_beat(64'hB003_B002_B001_B000, 8'h3C, 8'hFF, 1'b0, 4'h2, 4'h3, 2'h1);
    send_beat(64'hC003_C002_C001_C000, 8'hFF, 8'hFF, 1'b1, 4'h2, 4'h3, 2'h1);
    in_req.tvalid = 1'b0;
    drain();
    check("t2_count", 64'(got_data.size()), 64'(12));
    if (got_cyc.size() == 12) check("t2_span", 64'(got_cyc[11] - got_cyc[0]), 64'(11));
    if (got_data.size() == 12) begin
      check("t2_slice4", 64'(got_data[4]), 64'(16'hB000));
      check("t2_slice11", 64'(got_data[11]), 64'(16'hC003));
    end
    check("t2_in_tready_low_cycles", 64'(low_cnt), 64'(9));

    // Backpressure with the toggling ready pattern.
    clear_log();
    rdy_pattern = 1'b1;
    send_beat(64'hDDDD_CCCC_BBBB_AAAA, 8'hFF, 8'hFF, 1'b1, 4'h5, 4'h2, 2'h3);
    in_req.tvalid = 1'b0;
    drain();
    rdy_pattern = 1'b0;
    check("t3_count", 64'(got_data.size()), 64'(4));
    for (int i = 0; i < got_data.size(); i++) begin
      check("t3_id", 64'(got_id[i]), 64'(4'h5));
      check("t3_dest", 64'(got_dest[i]), 64'(4'h2));
    end
    if (got_data.size() == 4) check("t3_slice2", 64'(got_data[2]), 64'(16'hCCCC));

    // Reset asserted after slice 1 has been sent.
    clear_log();
    send_beat(64'h0404_0303_0202_0101, 8'hFF, 8'hFF, 1'b1, 4'h7, 4'h7, 2'h2);
    in_req.tvalid = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      #1;
      if (got_data.size() >= 2) done = 1'b1;
    end
    check("t4_wait_slice1", 64'(done), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_out_tvalid", 64'(out_req.tvalid), 64'(0));
    check("t4_rst_in_tready", 64'(in_rsp.tready), 64'(1));
    check("t4_rst_out_data", 64'(out_req.t.data), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t4_no_residual", 64'(got_data.size()), 64'(2));
    send_beat(64'h0808_0707_0606_0505, 8'hFF, 8'hFF, 1'b1, 4'h7, 4'h7, 2'h2);
    in_req.tvalid = 1'b0;
    drain();
    check("t4_after_count", 64'(got_data.size()), 64'(6));
    if (got_data.size() == 6) check("t4_restart_slice0", 64'(got_data[2]), 64'(16'h0505));

    // Partial keep.
    clear_log();
    send_beat(64'h9999_8888_7777_6666, 8'h0F, 8'h0F, 1'b1, 4'h1, 4'h2, 2'h0);
    in_req.tvalid = 1'b0;
    drain();
`ifdef AXI_STREAM_DW_DOWNSIZER_SKIP_NULL_EN
    check("t5_skip_count", 64'(got_data.size()), 64'(2));
    if (got_data.size() == 2) begin
      check("t5_skip_last0", 64'(got_last[0]), 64'(0));
      check("t5_skip_last1", 64'(got_last[1]), 64'(1));
      check("t5_skip_data1", 64'(got_data[1]), 64'(16'h7777));
    end
    clear_log();
    send_beat(64'h1234_5678_9ABC_DEF0, 8'h00, 8'h00, 1'b1, 4'h3, 4'h4, 2'h1);
    in_req.tvalid = 1'b0;
    drain();
    check("t5_null_count", 64'(got_data.size()), 64'(1));
    if (got_data.size() == 1) begin
      check("t5_null_keep", 64'(got_keep[0]), 64'(0));
      check("t5_null_last", 64'(got_last[0]), 64'(1));
      check("t5_null_id", 64'(got_id[0]), 64'(4'h3));
    end
`else
    check("t5_full_count", 64'(got_data.size()), 64'(4));
    if (got_data.size() == 4) begin
      check("t5_keep2", 64'(got_keep[2]), 64'(0));
      check("t5_keep3", 64'(got_keep[3]), 64'(0));
      check("t5_last2", 64'(got_last[2]), 64'(0));
      check("t5_last3", 64'(got_last[3]), 64'(1));
      check("t5_data3", 64'(got_data[3]), 64'(16'h9999));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
